// File: rtl/pc_fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage: NOP encoding,
// fetch FSM encodings and the {pc, inst} entry carried through the buffer.
package pc_fetch_stage_pkg;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  localparam logic [0:0] IF_RUN  = 1'b0;
  localparam logic [0:0] IF_HALT = 1'b1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_inst_fifo.sv
// Synchronous show-ahead FIFO holding fetched {pc, inst} words for ID.
// Flush wins over push/pop; push and pop may coincide at any fill level.
module fetch_inst_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;
  logic             empty;
  logic             full;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !flush && (!full || pop);
  assign do_pop  = pop && !flush && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// IF stage: owns the PC, issues in-order word fetches under a credit limit,
// squashes wrong-path responses after an EX redirect and buffers words for ID.
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        fetch_misalign
);

  localparam int CW = $clog2(MAX_OUTST) + 1;

  logic [0:0]    state_q;
  logic [31:0]   pc_q;
  logic [31:0]   resp_pc_q;
  logic [CW-1:0] outst_q;
  logic [CW-1:0] stale_q;
  logic [CW-1:0] outst_after_rv;
  logic [CW-1:0] buf_count;
  logic          misalign_q;
  logic          credit_ok;
  logic          hs;
  logic          rv;
  logic          drop;
  logic          push;
  logic          pop;
  logic          tgt_misaligned;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  // Every issued request reserves a buffer slot, so the buffer never overflows.
  assign credit_ok = ({1'b0, outst_q} + {1'b0, buf_count}) < (CW + 1)'(MAX_OUTST);
  assign imem_req  = !rst && (state_q == IF_RUN) && !jump_flag && credit_ok;
  assign imem_addr = pc_q;
  assign hs        = imem_req && imem_gnt;

  // A response with nothing outstanding belongs to a request from before reset.
  assign rv             = imem_rvalid && (outst_q != '0);
  assign outst_after_rv = outst_q - CW'(rv);
  assign drop           = rv && (stale_q != '0);
  assign push           = rv && !drop && !jump_flag;
  assign tgt_misaligned = (jump_target[1:0] != 2'b00);

  assign push_entry = '{pc: resp_pc_q, inst: imem_rdata};

  fetch_inst_fifo #(
    .DEPTH (MAX_OUTST),
    .WIDTH ($bits(fetch_entry_t))
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (jump_flag),
    .wdata (push_entry),
    .head  (head),
    .count (buf_count)
  );

  assign if_valid       = !rst && (buf_count != '0) && !jump_flag;
  assign pop            = if_valid && !stall;
  assign if_pc          = head.pc;
  assign if_inst        = if_valid ? head.inst : INST_NOP;
  assign fetch_misalign = misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IF_RUN;
      pc_q       <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      stale_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= jump_flag && tgt_misaligned;
      outst_q    <= outst_after_rv + CW'(hs);
      if (jump_flag) begin
        // Everything still in flight after this cycle is on the wrong path.
        pc_q      <= word_align(jump_target);
        resp_pc_q <= word_align(jump_target);
        stale_q   <= outst_after_rv;
        state_q   <= tgt_misaligned ? IF_HALT : IF_RUN;
      end else begin
        if (hs)   pc_q      <= pc_q + 32'd4;
        if (push) resp_pc_q <= resp_pc_q + 32'd4;
        if (drop) stale_q   <= stale_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Bench for pc_fetch_stage: a fixed cycle table, directed corner sequences and a
// random phase checked against an in-order memory and an expected-stream model.
module tb_pc_fetch_stage;
  import pc_fetch_stage_pkg::*;

  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, jump_flag, stall, imem_gnt, imem_rvalid;
  logic [31:0] jump_target, imem_rdata;
  logic        imem_req, if_valid, fetch_misalign;
  logic [31:0] imem_addr, if_pc, if_inst;

  always #5 clk = ~clk;

  pc_fetch_stage #(.RESET_PC(RESET_PC), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .rst(rst), .jump_flag(jump_flag), .jump_target(jump_target),
    .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .if_valid(if_valid),
    .if_pc(if_pc), .if_inst(if_inst), .fetch_misalign(fetch_misalign)
  );

  typedef struct {
    logic        stall, gnt, rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_inst;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // drive values for the next cycle
  logic        d_rst, d_stall, d_jump, d_gnt, d_rvalid;
  logic [31:0] d_target, d_rdata;
  // sampled DUT outputs
  logic        s_req, s_valid, s_mis;
  logic [31:0] s_addr, s_pc, s_inst;

  // memory model: in-order in-flight requests with remaining delay
  logic [31:0] q_addr[$];
  int          q_dly[$];
  int          orphan = 0;
  bit          auto_mem = 0;
  int          lat_min = 0, lat_max = 0;

  // reference model of the architectural streams
  bit          halted = 0, exp_mis = 0;
  logic [31:0] exp_fetch, exp_id;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_fetch = RESET_PC;
    exp_id    = RESET_PC;
    halted    = 0;
    exp_mis   = 0;
  endtask

  task automatic monitor();
    check1("misalign", s_mis, exp_mis);
    if (halted) check1("halt_req", s_req, 1'b0);
    if (s_req) check1("credit", (q_addr.size() - orphan) < MAX_OUTST, 1'b1);
    if (!s_valid) check32("nop", s_inst, INST_NOP);
    if (d_jump) begin
      check1("jmp_req", s_req, 1'b0);
      check1("jmp_valid", s_valid, 1'b0);
    end else begin
      if (s_req && d_gnt) begin
        check32("fetch_addr", s_addr, exp_fetch);
        exp_fetch += 32'd4;
      end
      if (s_valid) begin
        check32("id_pc", s_pc, exp_id);
        check32("id_inst", s_inst, inst_of(exp_id));
        if (!d_stall) exp_id += 32'd4;
      end
    end
    exp_mis = d_jump && (d_target[1:0] != 2'b00);
    if (d_jump) begin
      halted    = exp_mis;
      exp_fetch = d_target & ~32'h3;
      exp_id    = exp_fetch;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    rst         = d_rst;
    stall       = d_stall;
    jump_flag   = d_jump;
    jump_target = d_target;
    imem_gnt    = d_gnt;
    if (auto_mem) begin
      imem_rvalid = (q_addr.size() != 0) && (q_dly[0] == 0);
      imem_rdata  = imem_rvalid ? inst_of(q_addr[0]) : 32'hDEAD_BEEF;
    end else begin
      imem_rvalid = d_rvalid;
      imem_rdata  = d_rdata;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = if_valid;
    s_pc = if_pc; s_inst = if_inst; s_mis = fetch_misalign;
    if (auto_mem && !d_rst) monitor();
    @(posedge clk);
    if (auto_mem) begin
      if (imem_rvalid) begin
        void'(q_addr.pop_front());
        void'(q_dly.pop_front());
        if (orphan > 0) orphan--;
      end
      foreach (q_dly[i]) if (q_dly[i] > 0) q_dly[i]--;
      if (s_req && d_gnt) begin
        q_addr.push_back(s_addr);
        q_dly.push_back(int'($urandom_range(lat_max, lat_min)));
      end
    end
  endtask

  task automatic jump_to(input logic [31:0] t);
    d_jump = 1'b1; d_target = t;
    cycle();
    d_jump = 1'b0;
  endtask

  task automatic wait_valid_pc(input string name, input logic [31:0] pc, input int budget);
    bit seen = 0;
    for (int n = 0; n < budget && !seen; n++) begin
      cycle();
      if (s_valid) seen = 1;
    end
    check1({name, "_seen"}, seen, 1'b1);
    if (seen) check32({name, "_pc"}, s_pc, pc);
  endtask

  initial begin
    vec_t tbl[7];
    logic [31:0] held;
    bit          ok;

    rst = 1'b1; stall = 1'b0; jump_flag = 1'b0; jump_target = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    d_rst = 1'b1; d_stall = 1'b0; d_jump = 1'b0; d_target = '0;
    d_gnt = 1'b1; d_rvalid = 1'b0; d_rdata = '0;
    model_reset();

    // reset state
    for (int i = 0; i < 3; i++) begin
      cycle();
      check1("rst_req", s_req, 1'b0);
      check1("rst_valid", s_valid, 1'b0);
      check32("rst_inst", s_inst, INST_NOP);
      check1("rst_mis", s_mis, 1'b0);
    end

    // cycle table after reset release, memory driven by hand, 1-cycle responses
    tbl[0] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'd0,  1'b0, 32'd0,  INST_NOP};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'hAAAA_0000, 1'b1, 32'd4,  1'b0, 32'd0,  INST_NOP};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'hBBBB_0000, 1'b0, 32'd0,  1'b1, 32'd0,  32'hAAAA_0000};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 32'h0,         1'b1, 32'd8,  1'b1, 32'd4,  32'hBBBB_0000};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'hCCCC_0000, 1'b1, 32'd12, 1'b0, 32'd0,  INST_NOP};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'hDDDD_0000, 1'b0, 32'd0,  1'b1, 32'd8,  32'hCCCC_0000};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'd16, 1'b1, 32'd12, 32'hDDDD_0000};
    d_rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      d_stall = tbl[i].stall; d_gnt = tbl[i].gnt;
      d_rvalid = tbl[i].rvalid; d_rdata = tbl[i].rdata;
      cycle();
      check1($sformatf("tbl%0d_req", i), s_req, tbl[i].e_req);
      if (tbl[i].e_req) check32($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
      check1($sformatf("tbl%0d_valid", i), s_valid, tbl[i].e_valid);
      if (tbl[i].e_valid) check32($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
      check32($sformatf("tbl%0d_inst", i), s_inst, tbl[i].e_inst);
    end

    // hand over to the memory model; nothing is in flight now
    auto_mem = 1; d_rvalid = 1'b0; d_gnt = 1'b1;
    exp_fetch = 32'd16; exp_id = 32'd16;

    // stall with buffer filling: head held, requests stop once credits are used
    d_stall = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (i >= 4) begin
        check1("stall_req", s_req, 1'b0);
        check1("stall_valid", s_valid, 1'b1);
        check32("stall_pc", s_pc, 32'd16);
      end
    end
    d_stall = 1'b0;
    for (int i = 0; i < 10; i++) cycle();

    // redirect with two requests in flight
    lat_min = 2; lat_max = 2;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      cycle();
      if (q_addr.size() == 2) ok = 1;
    end
    check1("two_in_flight", ok, 1'b1);
    jump_to(32'h0000_0100);
    wait_valid_pc("j100", 32'h0000_0100, 20);
    lat_min = 0; lat_max = 0;
    for (int i = 0; i < 6; i++) cycle();

    // redirect coinciding with stall and a response
    d_stall = 1'b1;
    ok = 0;
    for (int n = 0; n < 20 && !ok; n++) begin
      cycle();
      if (q_addr.size() != 0 && q_dly[0] == 0) ok = 1;
    end
    check1("rv_pending", ok, 1'b1);
    jump_to(32'h0000_0400);
    d_stall = 1'b0;
    cycle();
    check1("jsr_valid", s_valid, 1'b0);
    check1("jsr_req", s_req, 1'b1);
    check32("jsr_addr", s_addr, 32'h0000_0400);
    cycle();
    check1("jsr_valid2", s_valid, 1'b0);
    cycle();
    check1("jsr_lat_valid", s_valid, 1'b1);
    check32("jsr_lat_pc", s_pc, 32'h0000_0400);

    // misaligned redirect halts fetch; again while halted; then recover
    jump_to(32'h0000_0102);
    cycle();
    check1("mis_pulse", s_mis, 1'b1);
    check1("mis_req", s_req, 1'b0);
    for (int i = 0; i < 4; i++) cycle();
    jump_to(32'h0000_0305);
    cycle();
    check1("mis_pulse2", s_mis, 1'b1);
    for (int i = 0; i < 3; i++) cycle();
    jump_to(32'h0000_0200);
    wait_valid_pc("j200", 32'h0000_0200, 20);

    // grant withheld: request and address held
    d_gnt = 1'b0;
    ok = 0;
    for (int n = 0; n < 10 && !ok; n++) begin
      cycle();
      if (s_req) ok = 1;
    end
    check1("gnt_req_seen", ok, 1'b1);
    held = s_addr;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check1("gnt_hold_req", s_req, 1'b1);
      check32("gnt_hold_addr", s_addr, held);
    end
    d_gnt = 1'b1;

    // PC wrap at the top of the address space
    jump_to(32'hFFFF_FFF8);
    ok = 0;
    for (int n = 0; n < 30 && !ok; n++) begin
      cycle();
      if (s_valid && s_pc == 32'h0) ok = 1;
    end
    check1("wrap_seen", ok, 1'b1);

    // reset in the middle of a burst; late responses must be ignored
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 4; i++) cycle();
    orphan = q_addr.size();
    d_rst = 1'b1; d_gnt = 1'b0;
    cycle();
    check1("mrst_req", s_req, 1'b0);
    check1("mrst_valid", s_valid, 1'b0);
    d_rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check1("mrst_quiet", s_valid, 1'b0);
    end
    d_gnt = 1'b1; lat_min = 0; lat_max = 0;
    wait_valid_pc("mrst_restart", RESET_PC, 20);

    // randomized traffic
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      d_gnt    = ($urandom_range(3, 0) != 0);
      d_stall  = ($urandom_range(9, 0) < 3);
      d_jump   = ($urandom_range(99, 0) < 3);
      d_target = $urandom;
      if ($urandom_range(4, 0) != 0) d_target[1:0] = 2'b00;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
